// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: rebuilds raster position from hsync/vsync edges, checks
// line and frame geometry, tracks lock, and taps one pixel for self-test.
module vga_timing_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int V_ACTIVE    = 480,
  parameter bit SYNC_POL    = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_ce,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  input  logic        clr_err,
  output logic        locked,
  output logic        de,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic [15:0] frame_cnt,
  output logic        h_err,
  output logic        v_err,
  output logic [11:0] probe_rgb,
  output logic        probe_valid
);
  // state     | meaning
  // S_SEARCH  | no vsync assert edge seen since reset
  // S_ACQUIRE | counting consecutive clean frames toward LOCK_FRAMES
  // S_LOCKED  | geometry verified, de enabled
  typedef enum logic [1:0] {S_SEARCH, S_ACQUIRE, S_LOCKED} state_t;

  localparam logic [9:0] HT1 = 10'(H_TOTAL - 1);
  localparam logic [9:0] HSW = 10'(H_SYNC);
  localparam logic [9:0] HA0 = 10'(H_SYNC + H_BP);
  localparam logic [9:0] HA1 = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0] VT1 = 10'(V_TOTAL - 1);
  localparam logic [9:0] VSW = 10'(V_SYNC);
  localparam logic [9:0] VA0 = 10'(V_SYNC + V_BP);
  localparam logic [9:0] VA1 = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [3:0] LF  = 4'(LOCK_FRAMES);

  state_t      state_q, state_d;
  logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, vs_lines_q, vs_lines_d;
  logic [3:0]  good_q, good_d;
  logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic        h_seen_q, h_seen_d, v_seen_q, v_seen_d;
  logic        v_pend_q, v_pend_d, frame_bad_q, frame_bad_d;
  logic        locked_q, locked_d, de_q, de_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        h_err_q, h_err_d, v_err_q, v_err_d;
  logic [11:0] probe_rgb_q, probe_rgb_d;
  logic        probe_valid_q, probe_valid_d;

  logic       hs_a, vs_a, hs_rise, hs_fall, vs_rise, vs_fall;
  logic       h_fail, v_fail, fail, active;
  logic [3:0] good_inc;

  assign hs_a     = (hsync == SYNC_POL);
  assign vs_a     = (vsync == SYNC_POL);
  assign hs_rise  = pix_ce & hs_a & ~hs_prev_q;
  assign hs_fall  = pix_ce & ~hs_a & hs_prev_q;
  assign vs_rise  = pix_ce & vs_a & ~vs_prev_q;
  assign vs_fall  = pix_ce & ~vs_a & vs_prev_q;
  assign good_inc = good_q + 4'd1;

  always_comb begin
    state_d       = state_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    vs_lines_d    = vs_lines_q;
    good_d        = good_q;
    hs_prev_d     = hs_prev_q;
    vs_prev_d     = vs_prev_q;
    h_seen_d      = h_seen_q;
    v_seen_d      = v_seen_q;
    v_pend_d      = v_pend_q;
    frame_bad_d   = frame_bad_q;
    locked_d      = locked_q;
    de_d          = de_q;
    x_d           = x_q;
    y_d           = y_q;
    frame_cnt_d   = frame_cnt_q;
    probe_rgb_d   = probe_rgb_q;
    probe_valid_d = 1'b0;
    h_fail        = 1'b0;
    v_fail        = 1'b0;
    fail          = 1'b0;
    active        = 1'b0;

    if (pix_ce) begin
      hs_prev_d = hs_a;
      vs_prev_d = vs_a;

      // h_cnt_d is the column of the current sample; the width check uses it
      if (hs_rise) h_cnt_d = '0;
      else if (h_cnt_q != 10'h3FF) h_cnt_d = h_cnt_q + 10'd1;
      h_fail = h_seen_q & ((hs_rise & (h_cnt_q != HT1)) | (hs_fall & (h_cnt_d != HSW)));
      if (hs_rise) h_seen_d = 1'b1;

      if (vs_rise) v_pend_d = 1'b1;
      if (hs_rise) begin
        if (v_pend_q | vs_rise) begin
          v_cnt_d  = '0;
          v_pend_d = 1'b0;
        end else if (v_cnt_q != 10'h3FF) begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end
      // a coincident vsync/hsync edge counts the first sync line
      vs_lines_d = (vs_rise ? 10'd0 : vs_lines_q) + {9'd0, hs_rise & vs_a};
      v_fail = v_seen_q & ((vs_rise & (v_cnt_q != VT1)) | (vs_fall & (vs_lines_q != VSW)));
      if (vs_rise) begin
        v_seen_d    = 1'b1;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end

      fail = h_fail | v_fail;
      case (state_q)
        S_SEARCH: if (vs_rise) begin
          state_d = S_ACQUIRE;
          good_d  = '0;
        end
        S_ACQUIRE: if (vs_rise) begin
          if (frame_bad_q | fail) begin
            good_d = '0;
          end else begin
            good_d = good_inc;
            if (good_inc == LF) state_d = S_LOCKED;
          end
        end
        S_LOCKED: if (fail) begin
          state_d = S_ACQUIRE;
          good_d  = '0;
        end
        default: state_d = S_SEARCH;
      endcase
      frame_bad_d = ~vs_rise & (frame_bad_q | fail);
      locked_d    = (state_d == S_LOCKED);

      active = (h_cnt_d >= HA0) && (h_cnt_d <= HA1) && (v_cnt_d >= VA0) && (v_cnt_d <= VA1);
      de_d   = locked_d & active;
      x_d    = h_cnt_d - HA0;
      y_d    = v_cnt_d - VA0;
      if (de_d && (x_d == probe_x) && (y_d == probe_y)) begin
        probe_rgb_d   = rgb;
        probe_valid_d = 1'b1;
      end
    end

    h_err_d = h_fail | (h_err_q & ~clr_err);
    v_err_d = v_fail | (v_err_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_SEARCH;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      vs_lines_q    <= '0;
      good_q        <= '0;
      hs_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      h_seen_q      <= 1'b0;
      v_seen_q      <= 1'b0;
      v_pend_q      <= 1'b0;
      frame_bad_q   <= 1'b0;
      locked_q      <= 1'b0;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frame_cnt_q   <= '0;
      h_err_q       <= 1'b0;
      v_err_q       <= 1'b0;
      probe_rgb_q   <= '0;
      probe_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      vs_lines_q    <= vs_lines_d;
      good_q        <= good_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      h_seen_q      <= h_seen_d;
      v_seen_q      <= v_seen_d;
      v_pend_q      <= v_pend_d;
      frame_bad_q   <= frame_bad_d;
      locked_q      <= locked_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_cnt_q   <= frame_cnt_d;
      h_err_q       <= h_err_d;
      v_err_q       <= v_err_d;
      probe_rgb_q   <= probe_rgb_d;
      probe_valid_q <= probe_valid_d;
    end
  end

  assign locked      = locked_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_cnt   = frame_cnt_q;
  assign h_err       = h_err_q;
  assign v_err       = v_err_q;
  assign probe_rgb   = probe_rgb_q;
  assign probe_valid = probe_valid_q;
endmodule

// File: tb/tb_vga_timing_monitor.sv
// Randomized self-checking bench for vga_timing_monitor on a scaled-down raster;
// expectations come from the bench's own line/pixel plan and a frame-level lock model.
module tb_vga_timing_monitor;
  localparam int HT = 40, HS = 4, HB = 3, HA = 30;
  localparam int VT = 20, VS = 2, VB = 3, VA = 12;
  localparam bit SP = 1'b0;
  localparam int LF = 2;
  localparam int HOFF = HS + HB;
  localparam int VOFF = VS + VB;
  localparam logic [11:0] CORNER_RGB = {4'(HA - 1), 4'(VA - 1), 4'hA};

  logic        clk = 1'b0, rst_n = 1'b1, pix_ce = 1'b0, clr_err = 1'b0;
  logic        hsync = ~SP, vsync = ~SP;
  logic [11:0] rgb = '0;
  logic [9:0]  probe_x = '0, probe_y = '0;
  logic        locked, de, h_err, v_err, probe_valid;
  logic [9:0]  x, y;
  logic [15:0] frame_cnt;
  logic [11:0] probe_rgb;

  vga_timing_monitor #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA),
    .SYNC_POL(SP), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .hsync(hsync), .vsync(vsync),
    .rgb(rgb), .probe_x(probe_x), .probe_y(probe_y), .clr_err(clr_err),
    .locked(locked), .de(de), .x(x), .y(y), .frame_cnt(frame_cnt),
    .h_err(h_err), .v_err(v_err), .probe_rgb(probe_rgb), .probe_valid(probe_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // reference model: 0 = searching, 1 = acquiring, 2 = locked
  int          m_st, m_good, m_frames, prev_len, prev_frame_lines;
  bit          m_bad, m_hseen, m_vseen, m_herr, m_verr;
  logic [11:0] exp_prgb;
  bit          clr_force, clr_rand_en, clr_on_fault;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_st = 0; m_good = 0; m_bad = 0; m_hseen = 0; m_vseen = 0;
    m_herr = 0; m_verr = 0; m_frames = 0; exp_prgb = '0;
  endfunction

  function automatic bit rand_clr();
    return clr_rand_en && ($urandom_range(0, 31) == 0);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; pix_ce = 1'b0; clr_err = 1'b0;
    #1;
    chk_eq("rst_locked", 32'(locked), 0);
    chk_eq("rst_de", 32'(de), 0);
    chk_eq("rst_x", 32'(x), 0);
    chk_eq("rst_y", 32'(y), 0);
    chk_eq("rst_frame_cnt", 32'(frame_cnt), 0);
    chk_eq("rst_h_err", 32'(h_err), 0);
    chk_eq("rst_v_err", 32'(v_err), 0);
    chk_eq("rst_probe_rgb", 32'(probe_rgb), 0);
    chk_eq("rst_probe_valid", 32'(probe_valid), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle_clk();
    pix_ce  = 1'b0;
    clr_err = clr_force | rand_clr();
    @(posedge clk);
    #1;
    m_herr = m_herr & ~clr_err;
    m_verr = m_verr & ~clr_err;
    chk_eq("probe_valid_idle", 32'(probe_valid), 0);
    chk_eq("h_err_idle", 32'(h_err), 32'(m_herr));
    chk_eq("v_err_idle", 32'(v_err), 32'(m_verr));
  endtask

  task automatic send_px(input int ln, input int px, input int vsl);
    bit hr, vsr, vsf, hf, vf, fail, act, e_de, e_pv;
    logic [11:0] c;
    repeat ($urandom_range(0, 2)) idle_clk();
    hr   = (px == 0);
    vsr  = hr && (ln == 0);
    vsf  = hr && (ln == vsl);
    hf   = hr && m_hseen && (prev_len != HT);
    vf   = (vsr && m_vseen && (prev_frame_lines != VT)) || (vsf && m_vseen && (vsl != VS));
    fail = hf | vf;
    act  = (px >= HOFF) && (px < HOFF + HA) && (ln >= VOFF) && (ln < VOFF + VA);
    c    = act ? {4'(px - HOFF), 4'(ln - VOFF), 4'hA} : 12'($urandom);
    pix_ce  = 1'b1;
    hsync   = (px < HS) ? SP : ~SP;
    vsync   = (ln < vsl) ? SP : ~SP;
    rgb     = c;
    clr_err = clr_force | (clr_on_fault & fail) | rand_clr();
    @(posedge clk);
    #1;
    pix_ce = 1'b0;

    m_herr = hf | (m_herr & ~clr_err);
    m_verr = vf | (m_verr & ~clr_err);
    if (hr) m_hseen = 1;
    if (vsr) begin m_vseen = 1; m_frames++; end
    if (m_st == 0) begin
      if (vsr) begin m_st = 1; m_good = 0; end
    end else if (m_st == 1) begin
      if (vsr) begin
        if (m_bad || fail) m_good = 0;
        else begin
          m_good++;
          if (m_good == LF) m_st = 2;
        end
      end
    end else if (fail) begin
      m_st = 1; m_good = 0;
    end
    m_bad = vsr ? 1'b0 : (m_bad | fail);

    e_de = (m_st == 2) && act;
    e_pv = e_de && ((px - HOFF) == int'(probe_x)) && ((ln - VOFF) == int'(probe_y));
    if (e_pv) exp_prgb = c;
    chk_eq("locked", 32'(locked), 32'(m_st == 2));
    chk_eq("de", 32'(de), 32'(e_de));
    if (e_de) begin
      chk_eq("x", 32'(x), px - HOFF);
      chk_eq("y", 32'(y), ln - VOFF);
    end
    chk_eq("h_err", 32'(h_err), 32'(m_herr));
    chk_eq("v_err", 32'(v_err), 32'(m_verr));
    chk_eq("probe_valid", 32'(probe_valid), 32'(e_pv));
    chk_eq("probe_rgb", 32'(probe_rgb), 32'(exp_prgb));
  endtask

  task automatic run_frame(input int n_lines, input int vsl, input int short_ln,
                           input int rst_ln, input int rst_px);
    for (int ln = 0; ln < n_lines; ln++) begin
      int len;
      len = (ln == short_ln) ? HT - 1 : HT;
      for (int px = 0; px < len; px++) begin
        if (ln == rst_ln && px == rst_px) do_reset();
        send_px(ln, px, vsl);
      end
      prev_len = len;
    end
    prev_frame_lines = n_lines;
    chk_eq("frame_cnt", 32'(frame_cnt), m_frames % 65536);
  endtask

  task automatic rand_probe();
    probe_x = 10'($urandom_range(0, HA - 1));
    probe_y = 10'($urandom_range(0, VA - 1));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached after %0d checks", n_checks);
    $fatal(1, "bench timeout");
  end

  initial begin
    clr_force = 0; clr_rand_en = 0; clr_on_fault = 0;
    prev_len = HT; prev_frame_lines = VT;
    model_reset();
    #2;
    do_reset();

    // clean frames: lock at the third vsync edge, probe the first active pixel
    probe_x = '0; probe_y = '0;
    repeat (3) run_frame(VT, VS, -1, -1, -1);
    chk_eq("lock_after_3_edges", 32'(locked), 1);
    chk_eq("probe_origin", 32'(probe_rgb), 32'(12'h00A));
    chk_eq("frame_cnt_3", 32'(frame_cnt), 3);

    probe_x = 10'(HA - 1); probe_y = 10'(VA - 1);
    run_frame(VT, VS, -1, -1, -1);
    chk_eq("probe_corner", 32'(probe_rgb), 32'(CORNER_RGB));

    // short line while locked, clr_err coincident with the detection
    clr_on_fault = 1;
    run_frame(VT, VS, $urandom_range(VT - 2, VOFF), -1, -1);
    clr_on_fault = 0;
    chk_eq("h_err_sticky", 32'(h_err), 1);
    chk_eq("unlock_short_line", 32'(locked), 0);

    clr_rand_en = 1;
    rand_probe();
    repeat (2) run_frame(VT, VS, -1, -1, -1);
    clr_rand_en = 0;
    chk_eq("h_err_cleared", 32'(h_err), 0);
    rand_probe();
    run_frame(VT, VS, -1, -1, -1);
    chk_eq("relock", 32'(locked), 1);

    // three-line vsync
    run_frame(VT, VS + 1, -1, -1, -1);
    chk_eq("v_err_width", 32'(v_err), 1);
    chk_eq("unlock_vs_width", 32'(locked), 0);
    clr_rand_en = 1;
    run_frame(VT, VS, -1, -1, -1);
    clr_rand_en = 0;
    rand_probe();
    run_frame(VT, VS, -1, -1, -1);
    chk_eq("v_err_cleared", 32'(v_err), 0);

    // one frame short by a line, detected at the next vsync edge
    run_frame(VT - 1, VS, -1, -1, -1);
    chk_eq("locked_before_short_frame_end", 32'(locked), 1);
    run_frame(VT, VS, -1, -1, -1);
    chk_eq("v_err_period", 32'(v_err), 1);
    chk_eq("unlock_period", 32'(locked), 0);

    // reset mid-frame: no errors from the partial line/frame, re-lock after 3 edges
    run_frame(VT, VS, -1, $urandom_range(VT - 1, VS), $urandom_range(HT - 1, HOFF));
    rand_probe();
    repeat (2) run_frame(VT, VS, -1, -1, -1);
    chk_eq("no_lock_two_edges_after_rst", 32'(locked), 0);
    run_frame(VT, VS, -1, -1, -1);
    chk_eq("lock_after_rst", 32'(locked), 1);
    chk_eq("h_err_after_rst", 32'(h_err), 0);
    chk_eq("v_err_after_rst", 32'(v_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
